// File: rtl/trisc_pkg.sv
// Shared definitions for the TRISC execute controller: opcodes, instruction
// field positions and the controller state encoding.
package trisc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int INSTR_W  = 10;
    localparam int IMM_BIT  = 9;
    localparam int OP_LSB   = 7;
    localparam int RD_LSB   = 4;
    localparam int RS1_LSB  = 2;
    localparam int RS2_LSB  = 0;
    localparam int IMMV_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/trisc_regfile.sv
// NREGS x DW register file: one write port, three combinational read ports
// (two operand reads and one debug/display read).
module trisc_regfile #(
    parameter int NREGS = 4,
    parameter int DW    = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata2_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o
);

    logic [NREGS-1:0][DW-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we_i) regs_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    assign rdata1_o   = regs_q[raddr1_i];
    assign rdata2_o   = regs_q[raddr2_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/trisc_exec_ctrl.sv
// Two-state execute controller in front of the 4-bit ALU: latches operands at
// acceptance, writes the ALU result or immediate back one edge later.
// Optional build macro: TRISC_STICKY_OVR_EN (ovr_flag accumulates until cleared).
module trisc_exec_ctrl
    import trisc_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [INSTR_W-1:0]         instr,
    output logic [DW-1:0]              alu_a,
    output logic [DW-1:0]              alu_b,
    output logic                       alu_s0,
    output logic                       alu_s1,
    input  logic [DW-1:0]              alu_r,
    input  logic                       alu_cout,
    input  logic                       alu_ovr,
    output logic                       carry_flag,
    output logic                       ovr_flag,
    input  logic                       flag_clr,
    output logic                       wb_done,
    input  logic [$clog2(NREGS)-1:0]   dbg_sel,
    output logic [DW-1:0]              dbg_data
);

    localparam int AW = $clog2(NREGS);

    state_e        state_q, state_d;
    logic          imm_q, imm_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] immv_q, immv_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]    op_q, op_d;
    logic          carry_q, carry_d, ovr_q, ovr_d;
    logic          wb_q, wb_d;
    logic          we;
    logic [DW-1:0] wdata, rs1_data, rs2_data;
    logic          unused_instr;

    // Bit 6 of the instruction word is reserved.
    assign unused_instr = instr[6];

    trisc_regfile #(.NREGS(NREGS), .DW(DW)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we),
        .waddr_i    (rd_q),
        .wdata_i    (wdata),
        .raddr1_i   (instr[RS1_LSB +: AW]),
        .rdata1_o   (rs1_data),
        .raddr2_i   (instr[RS2_LSB +: AW]),
        .rdata2_o   (rs2_data),
        .dbg_addr_i (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        rd_d    = rd_q;
        immv_d  = immv_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        op_d    = op_q;
        carry_d = carry_q;
        ovr_d   = ovr_q;
        wb_d    = 1'b0;
        we      = 1'b0;
        wdata   = alu_r;
        // A coinciding ALU writeback below overrides this clear.
        if (flag_clr) begin
            carry_d = 1'b0;
            ovr_d   = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    imm_d   = instr[IMM_BIT];
                    op_d    = instr[OP_LSB +: 2];
                    rd_d    = instr[RD_LSB +: AW];
                    immv_d  = instr[IMMV_LSB +: DW];
                    alu_a_d = rs1_data;
                    alu_b_d = rs2_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                we      = 1'b1;
                wb_d    = 1'b1;
                state_d = IDLE;
                if (imm_q) begin
                    wdata = immv_q;
                end else begin
                    carry_d = alu_cout;
`ifdef TRISC_STICKY_OVR_EN
                    ovr_d   = ovr_q | alu_ovr;
`else
                    ovr_d   = alu_ovr;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            imm_q   <= 1'b0;
            rd_q    <= '0;
            immv_q  <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            op_q    <= 2'b00;
            carry_q <= 1'b0;
            ovr_q   <= 1'b0;
            wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
            immv_q  <= immv_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            ovr_q   <= ovr_d;
            wb_q    <= wb_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_s0      = op_q[0];
    assign alu_s1      = op_q[1];
    assign carry_flag  = carry_q;
    assign ovr_flag    = ovr_q;
    assign wb_done     = wb_q;

endmodule

// File: tb/tb_trisc_exec_ctrl.sv
// Directed bench for trisc_exec_ctrl with a behavioural 4-bit ALU closing the loop.
module tb_trisc_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] instr;
    logic [3:0] alu_a, alu_b, alu_r;
    logic       alu_s0, alu_s1, alu_cout, alu_ovr;
    logic       carry_flag, ovr_flag, flag_clr, wb_done;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    int total = 0;
    int bad   = 0;
`ifdef TRISC_STICKY_OVR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    trisc_exec_ctrl #(.NREGS(4), .DW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s0      (alu_s0),
        .alu_s1      (alu_s1),
        .alu_r       (alu_r),
        .alu_cout    (alu_cout),
        .alu_ovr     (alu_ovr),
        .carry_flag  (carry_flag),
        .ovr_flag    (ovr_flag),
        .flag_clr    (flag_clr),
        .wb_done     (wb_done),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: 00 add, 01 sub (carry = no-borrow), 10 and, 11 xor.
    logic [4:0] sum5;
    always_comb begin
        sum5     = 5'd0;
        alu_r    = 4'd0;
        alu_cout = 1'b0;
        alu_ovr  = 1'b0;
        case ({alu_s1, alu_s0})
            2'b00: begin
                sum5     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r    = sum5[3:0];
                alu_cout = sum5[4];
                alu_ovr  = (alu_a[3] == alu_b[3]) && (sum5[3] != alu_a[3]);
            end
            2'b01: begin
                sum5     = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_r    = sum5[3:0];
                alu_cout = sum5[4];
                alu_ovr  = (alu_a[3] != alu_b[3]) && (sum5[3] != alu_a[3]);
            end
            2'b10:   alu_r = alu_a & alu_b;
            default: alu_r = alu_a ^ alu_b;
        endcase
    end

    function automatic logic [9:0] f_imm(input logic [1:0] rd, input logic [3:0] v);
        return {1'b1, 2'b00, 1'b0, rd, v};
    endfunction

    function automatic logic [9:0] f_alu(input logic [1:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
        return {1'b0, op, 1'b0, rd, rs1, rs2};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        dbg_sel = idx;
        #1;
        chk(tag, {4'd0, dbg_data}, {4'd0, exp});
    endtask

    // Issue one instruction from IDLE; returns #1 after E1 (the wb_done cycle).
    task automatic exec(input logic [9:0] ins, input logic clr_at_e1);
        chk("ready_before_issue", {7'd0, instr_ready}, 8'd1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        flag_clr    = clr_at_e1;
        @(posedge clk); #1;
        flag_clr    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; flag_clr = 1'b0; dbg_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", {7'd0, instr_ready}, 8'd1);
        chk("rst_flags", {6'd0, carry_flag, ovr_flag}, 8'd0);
        chk("rst_wb", {7'd0, wb_done}, 8'd0);
        chk("rst_alu", {alu_a, alu_b}, 8'd0);
        chk("rst_sel", {6'd0, alu_s1, alu_s0}, 8'd0);
        chk_reg("rst_r0", 2'd0, 4'h0);
        chk_reg("rst_r3", 2'd3, 4'h0);

        // 3 + 5 = 8: signed overflow, no carry
        exec(f_imm(2'd1, 4'h3), 1'b0);
        exec(f_imm(2'd2, 4'h5), 1'b0);
        exec(f_alu(2'b00, 2'd0, 2'd1, 2'd2), 1'b0);
        chk("add1_wb", {7'd0, wb_done}, 8'd1);
        chk("add1_flags", {6'd0, carry_flag, ovr_flag}, 8'b01);
        chk_reg("add1_r0", 2'd0, 4'h8);
        @(posedge clk); #1;
        chk("add1_wb_pulse_end", {7'd0, wb_done}, 8'd0);

        // 0xF + 1 = 0 with carry; then AND
        exec(f_imm(2'd1, 4'hF), 1'b0);
        exec(f_imm(2'd2, 4'h1), 1'b0);
        exec(f_alu(2'b00, 2'd3, 2'd1, 2'd2), 1'b0);
        chk("add2_flags", {6'd0, carry_flag, ovr_flag}, 8'b10);
        chk_reg("add2_r3", 2'd3, 4'h0);
        exec(f_alu(2'b10, 2'd3, 2'd1, 2'd2), 1'b0);
        chk("and_flags", {6'd0, carry_flag, ovr_flag}, 8'b00);
        chk_reg("and_r3", 2'd3, 4'h1);

        // Back-to-back: imm r0<=7 then add r1=r0+r0 (=0xE, ovr)
        instr_valid = 1'b1;
        instr = f_imm(2'd0, 4'h7);
        @(posedge clk); #1;
        instr = f_alu(2'b00, 2'd1, 2'd0, 2'd0);
        chk("b2b_exec_not_ready", {7'd0, instr_ready}, 8'd0);
        @(posedge clk); #1;
        chk("b2b_wb1", {6'd0, wb_done, instr_ready}, 8'b11);
        chk_reg("b2b_r0", 2'd0, 4'h7);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("b2b_second_accepted", {6'd0, wb_done, instr_ready}, 8'b00);
        @(posedge clk); #1;
        chk("b2b_wb2", {7'd0, wb_done}, 8'd1);
        chk("b2b_flags", {6'd0, carry_flag, ovr_flag}, 8'b01);
        chk_reg("b2b_r1", 2'd1, 4'hE);

        // sub r1 = r1 - r2 with 2 - 3; old r1 is the operand
        exec(f_imm(2'd1, 4'h2), 1'b0);
        exec(f_imm(2'd2, 4'h3), 1'b0);
        instr_valid = 1'b1;
        instr = f_alu(2'b01, 2'd1, 2'd1, 2'd2);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("sub_sel", {6'd0, alu_s1, alu_s0}, 8'b01);
        chk("sub_operands", {alu_a, alu_b}, 8'h23);
        @(posedge clk); #1;
        chk("sub_flags", {6'd0, carry_flag, ovr_flag}, 8'b00);
        chk("sub_operands_hold", {alu_a, alu_b}, 8'h23);
        chk_reg("sub_r1", 2'd1, 4'hF);

        // flag_clr coinciding with an overflowing add: writeback wins
        exec(f_imm(2'd0, 4'h4), 1'b0);
        exec(f_imm(2'd3, 4'h4), 1'b0);
        exec(f_alu(2'b00, 2'd2, 2'd0, 2'd3), 1'b1);
        chk("clr_e1_flags", {6'd0, carry_flag, ovr_flag}, 8'b01);
        chk_reg("clr_e1_r2", 2'd2, 4'h8);
        // 4 + 0xF = 3 with carry, no overflow
        exec(f_alu(2'b00, 2'd3, 2'd0, 2'd1), 1'b0);
        chk("sticky_flags", {6'd0, carry_flag, ovr_flag}, {6'd0, 1'b1, STICKY});
        chk_reg("sticky_r3", 2'd3, 4'h3);

        // Reset in the middle of EXEC drops the instruction
        instr_valid = 1'b1;
        instr = f_imm(2'd0, 4'h9);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("rstx_in_exec", {7'd0, instr_ready}, 8'd0);
        rst = 1'b1;
        #1;
        chk("rstx_async_ready", {7'd0, instr_ready}, 8'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstx_wb", {7'd0, wb_done}, 8'd0);
        chk("rstx_ready", {7'd0, instr_ready}, 8'd1);
        chk("rstx_flags", {6'd0, carry_flag, ovr_flag}, 8'b00);
        chk_reg("rstx_r0", 2'd0, 4'h0);
        chk_reg("rstx_r1", 2'd1, 4'h0);
        chk_reg("rstx_r3", 2'd3, 4'h0);

        // Standalone flag_clr: 8 + 8 sets both flags, then clear
        exec(f_imm(2'd0, 4'h8), 1'b0);
        exec(f_alu(2'b00, 2'd2, 2'd0, 2'd0), 1'b0);
        chk("clr_pre_flags", {6'd0, carry_flag, ovr_flag}, 8'b11);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clr_flags", {6'd0, carry_flag, ovr_flag}, 8'b00);
        chk_reg("clr_r2", 2'd2, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
